// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with a ready handshake and timeout for data memory/I/O.
// Define CPU_SEQ_ILLEGAL_HALT_EN to make an undefined opcode halt the sequencer instead of retiring as a NOP.
module cpu_seq_ctrl #(
    parameter int unsigned CNT_BITS    = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          opcode1,
    input  logic                br_taken,
    input  logic                mem_ready,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic                alu_src_imm,
    output logic                alu_cmp,
    output logic                rf_we,
    output logic [1:0]          wb_sel,
    output logic                mem_re,
    output logic                mem_we,
    output logic                mem_err,
    output logic                halted,
    output logic [2:0]          state,
    output logic [CNT_BITS-1:0] instr_count
);

    localparam int unsigned WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0] OP_ALUR  = 4'b0000;
    localparam logic [3:0] OP_ALUI  = 4'b1000;
    localparam logic [3:0] OP_CMPR  = 4'b0010;
    localparam logic [3:0] OP_CMPI  = 4'b1010;
    localparam logic [3:0] OP_JAL   = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1001;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BCOND = 4'b0110;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_BITS-1:0]   r_cnt;
    logic [WW-1:0]         r_wait;
    logic                  r_err;

    logic w_is_lw, w_is_sw, w_is_jal, w_is_bcond, w_to_wb, w_src_imm, w_cmp;
    logic w_timeout;

    assign w_is_lw    = (opcode1 == OP_LW);
    assign w_is_sw    = (opcode1 == OP_SW);
    assign w_is_jal   = (opcode1 == OP_JAL);
    assign w_is_bcond = (opcode1 == OP_BCOND);
    assign w_to_wb    = (opcode1 == OP_ALUR) || (opcode1 == OP_ALUI) || (opcode1 == OP_CMPR) ||
                        (opcode1 == OP_CMPI) || w_is_jal;
    assign w_src_imm  = opcode1[3] || w_is_sw;
    assign w_cmp      = (opcode1 == OP_CMPR) || (opcode1 == OP_CMPI) || w_is_bcond;

    // Everything is gated by reset so strobes fall asynchronously, even mid-MEM.
    always_comb begin
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;
        alu_src_imm = 1'b0;
        alu_cmp     = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = 2'd0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        w_timeout   = 1'b0;
        w_next      = r_state;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_imm = w_src_imm;
                    alu_cmp     = w_cmp;
                    w_next      = S_EXEC;
                end
                S_EXEC: begin
                    alu_src_imm = w_src_imm;
                    alu_cmp     = w_cmp;
                    if (w_to_wb) begin
                        w_next = S_WB;
                    end else if (w_is_lw || w_is_sw) begin
                        w_next = S_MEM;
                    end else if (w_is_bcond) begin
                        pc_we  = 1'b1;
                        pc_sel = {1'b0, br_taken};
                        w_next = S_FETCH;
                    end else begin
`ifdef CPU_SEQ_ILLEGAL_HALT_EN
                        w_next = S_HALT;
`else
                        pc_we  = 1'b1;
                        w_next = S_FETCH;
`endif
                    end
                end
                S_MEM: begin
                    alu_src_imm = w_src_imm;
                    alu_cmp     = w_cmp;
                    if (mem_ready) begin
                        mem_re = w_is_lw;
                        mem_we = w_is_sw;
                        if (w_is_lw) begin
                            w_next = S_WB;
                        end else begin
                            pc_we  = 1'b1;
                            w_next = S_FETCH;
                        end
                    end else if (r_wait == WW'(MEM_TIMEOUT - 1)) begin
                        // MEM_TIMEOUT-th cycle without ready: abandon the access and retire.
                        w_timeout = 1'b1;
                        pc_we     = 1'b1;
                        w_next    = S_FETCH;
                    end else begin
                        mem_re = w_is_lw;
                        mem_we = w_is_sw;
                    end
                end
                S_WB: begin
                    alu_src_imm = w_src_imm;
                    alu_cmp     = w_cmp;
                    rf_we       = 1'b1;
                    wb_sel      = w_is_lw ? 2'd1 : (w_is_jal ? 2'd2 : 2'd0);
                    pc_we       = 1'b1;
                    pc_sel      = w_is_jal ? 2'd2 : 2'd0;
                    w_next      = S_FETCH;
                end
                S_HALT: begin
                    w_next = S_HALT;
                end
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (pc_we) begin
                r_cnt <= r_cnt + CNT_BITS'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (r_state == S_MEM && w_next == S_MEM) begin
                r_wait <= r_wait + WW'(1);
            end else begin
                r_wait <= '0;
            end
        end
    end

    assign state       = r_state;
    assign instr_count = r_cnt;
    assign mem_err     = r_err;
`ifdef CPU_SEQ_ILLEGAL_HALT_EN
    assign halted      = (r_state == S_HALT);
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: directed and random instruction streams against a per-instruction cycle script model.
module tb_cpu_seq_ctrl;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode1;
    logic       br_taken;
    logic       mem_ready;
    logic       ir_we, pc_we, alu_src_imm, alu_cmp, rf_we, mem_re, mem_we, mem_err, halted;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] state;
    logic [3:0] instr_count;

    always #5 clk = ~clk;

    cpu_seq_ctrl #(.CNT_BITS(4), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .opcode1(opcode1), .br_taken(br_taken), .mem_ready(mem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_imm(alu_src_imm), .alu_cmp(alu_cmp),
        .rf_we(rf_we), .wb_sel(wb_sel), .mem_re(mem_re), .mem_we(mem_we), .mem_err(mem_err),
        .halted(halted), .state(state), .instr_count(instr_count)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       ir;
        logic       pc;
        logic [1:0] psel;
        logic       src;
        logic       cmp;
        logic       rf;
        logic [1:0] wsel;
        logic       re;
        logic       we;
    } exp_t;

    int         tests = 0;
    int         fails = 0;
    logic [3:0] e_cnt = 4'd0;
    logic       e_err = 1'b0;
    logic       e_halt = 1'b0;

    function automatic exp_t sample();
        return {state, ir_we, pc_we, pc_sel, alu_src_imm, alu_cmp, rf_we, wb_sel, mem_re, mem_we};
    endfunction

    function automatic logic is_def(input logic [3:0] op);
        case (op)
            4'b0000, 4'b1000, 4'b0010, 4'b1010, 4'b1011, 4'b1001, 4'b0101, 4'b0110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check(tag, {17'b0, sample()}, {17'b0, e});
        check({tag, "/cnt_err_halt"}, {26'b0, instr_count, mem_err, halted}, {26'b0, e_cnt, e_err, e_halt});
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then account for the coming edge.
    task automatic step(input exp_t e, input logic [3:0] op, input logic br, input logic rdy,
                        input logic retire, input logic err_set, input string tag);
        @(negedge clk);
        opcode1   = op;
        br_taken  = br;
        mem_ready = rdy;
        #1;
        check_all(tag, e);
        if (retire) e_cnt = e_cnt + 4'd1;
        if (err_set) e_err = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        exp_t z;
        z = '0;
        reset  = 1'b1;
        e_cnt  = 4'd0;
        e_err  = 1'b0;
        e_halt = 1'b0;
        #1;
        check_all(tag, z);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // w = ready-low cycles before ready in MEM (w >= TO means never ready); abort_k = MEM cycle to reset in (-1: none).
    task automatic run_instr(input logic [3:0] op, input logic br, input int unsigned w, input int abort_k);
        exp_t e;
        logic src, cmp, lw, sw, jal;
        src = op[3] || (op == 4'b0101);
        cmp = (op == 4'b0010) || (op == 4'b1010) || (op == 4'b0110);
        lw  = (op == 4'b1001);
        sw  = (op == 4'b0101);
        jal = (op == 4'b1011);

        e = '0; e.st = 3'd0; e.ir = 1'b1;
        step(e, op, br, rnd_bit(), 1'b0, 1'b0, "fetch");
        e = '0; e.st = 3'd1; e.src = src; e.cmp = cmp;
        step(e, op, br, rnd_bit(), 1'b0, 1'b0, "decode");

        e = '0; e.st = 3'd2; e.src = src; e.cmp = cmp;
        if (op == 4'b0110) begin
            e.pc = 1'b1; e.psel = {1'b0, br};
            step(e, op, br, rnd_bit(), 1'b1, 1'b0, "exec_bcond");
            return;
        end
        if (!is_def(op)) begin
`ifdef CPU_SEQ_ILLEGAL_HALT_EN
            step(e, op, br, rnd_bit(), 1'b0, 1'b0, "exec_illegal");
            e_halt = 1'b1;
            e = '0; e.st = 3'd7;
            for (int unsigned i = 0; i < 3; i++) step(e, op, br, rnd_bit(), 1'b0, 1'b0, "halt");
            do_reset("halt_reset");
`else
            e.pc = 1'b1;
            step(e, op, br, rnd_bit(), 1'b1, 1'b0, "exec_nop");
`endif
            return;
        end
        step(e, op, br, rnd_bit(), 1'b0, 1'b0, "exec");

        if (lw || sw) begin
            for (int k = 0; k < int'(TO); k++) begin
                e = '0; e.st = 3'd3; e.src = src; e.cmp = cmp;
                if (k == abort_k) begin
                    e.re = lw; e.we = sw;
                    @(negedge clk);
                    mem_ready = 1'b0;
                    #1;
                    check_all("mem_pre_abort", e);
                    do_reset("mem_abort_reset");
                    return;
                end
                if (k == int'(w)) begin
                    e.re = lw; e.we = sw; e.pc = sw;
                    step(e, op, br, 1'b1, sw, 1'b0, "mem_ready");
                    if (sw) return;
                    break;
                end else if (k == int'(TO) - 1) begin
                    e.pc = 1'b1;
                    step(e, op, br, 1'b0, 1'b1, 1'b1, "mem_timeout");
                    return;
                end else begin
                    e.re = lw; e.we = sw;
                    step(e, op, br, 1'b0, 1'b0, 1'b0, "mem_wait");
                end
            end
        end

        e = '0; e.st = 3'd4; e.src = src; e.cmp = cmp; e.rf = 1'b1; e.pc = 1'b1;
        e.wsel = lw ? 2'd1 : (jal ? 2'd2 : 2'd0);
        e.psel = jal ? 2'd2 : 2'd0;
        step(e, op, br, rnd_bit(), 1'b1, 1'b0, "wb");
    endtask

    task automatic run_random(input int unsigned n);
        logic [3:0]  op;
        int unsigned w;
        for (int unsigned i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 15));
`ifdef CPU_SEQ_ILLEGAL_HALT_EN
            if (!is_def(op)) op = 4'b0000;
`endif
            w = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
            run_instr(op, rnd_bit(), w, -1);
        end
    endtask

    initial begin
        reset     = 1'b1;
        opcode1   = 4'b1001;
        br_taken  = 1'b0;
        mem_ready = 1'b1;
        do_reset("reset");

        run_instr(4'b0000, 1'b0, 0, -1);
        run_instr(4'b0110, 1'b1, 0, -1);
        run_instr(4'b0110, 1'b0, 0, -1);
        run_instr(4'b1001, 1'b0, 3, -1);
        run_instr(4'b0101, 1'b0, 1, -1);
        run_instr(4'b1011, 1'b0, 0, -1);
        run_instr(4'b0101, 1'b0, 20, -1);
        run_instr(4'b1001, 1'b0, 20, -1);
        run_instr(4'b1111, 1'b0, 0, -1);
        run_instr(4'b1001, 1'b0, 0, -1);

        run_random(60);

        run_instr(4'b0101, 1'b0, 20, 2);
        run_instr(4'b1001, 1'b0, 20, 0);
        run_random(20);

`ifdef CPU_SEQ_ILLEGAL_HALT_EN
        run_instr(4'b1111, 1'b0, 0, -1);
        run_instr(4'b0000, 1'b0, 0, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
